// File: rtl/multi_one_shot.sv
// CHANNELS-wide one-shot: selectable edge detect, PULSE_W-cycle pulse, retrigger, overrun flags.
// Define ONE_SHOT_SYNC_EN to insert a 2-flop input synchronizer per channel.
module multi_one_shot #(
    parameter int CHANNELS  = 4,
    parameter int PULSE_W   = 1,
    parameter int EDGE_MODE = 0,
    parameter int RETRIGGER = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] data_in,
    input  logic                clr_overrun,
    output logic [CHANNELS-1:0] data_out,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] overrun
);

    localparam int CNT_W = $clog2(PULSE_W + 1);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              st_q  [CHANNELS];
    state_t              st_d  [CHANNELS];
    logic [CNT_W-1:0]    cnt_q [CHANNELS];
    logic [CNT_W-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] sig;
    logic [CHANNELS-1:0] prev_q;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] edge_raw;
    logic [CHANNELS-1:0] edge_det;
    logic [CHANNELS-1:0] ovr_q;
    logic [CHANNELS-1:0] ovr_d;
    logic                primed_q;
    logic                prime_ok;

`ifdef ONE_SHOT_SYNC_EN
    logic [CHANNELS-1:0] s1_q;
    logic [CHANNELS-1:0] s2_q;
    logic [1:0]          warm_q;

    // Priming waits until the synchronizer holds a post-reset sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            warm_q <= 2'd0;
        end else begin
            s1_q <= data_in;
            s2_q <= s1_q;
            if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
        end
    end

    assign sig      = s2_q;
    assign prime_ok = (warm_q == 2'd2);
`else
    assign sig      = data_in;
    assign prime_ok = 1'b1;
`endif

    assign rise = sig & ~prev_q;
    assign fall = ~sig & prev_q;

    always_comb begin
        edge_raw = rise | fall;
        if (EDGE_MODE == 0) edge_raw = rise;
        else if (EDGE_MODE == 1) edge_raw = fall;
    end

    assign edge_det = edge_raw & en & {CHANNELS{primed_q}};

    always_comb begin
        ovr_d = clr_overrun ? '0 : ovr_q;
        for (int i = 0; i < CHANNELS; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            if (!en[i]) begin
                st_d[i]  = IDLE;
                cnt_d[i] = '0;
            end else begin
                unique case (st_q[i])
                    IDLE: begin
                        if (edge_det[i]) begin
                            st_d[i]  = ACTIVE;
                            cnt_d[i] = LOAD;
                        end
                    end
                    ACTIVE: begin
                        if (edge_det[i]) ovr_d[i] = 1'b1;
                        if (edge_det[i] && RETRIGGER != 0) begin
                            cnt_d[i] = LOAD;
                        end else begin
                            cnt_d[i] = cnt_q[i] - ONE;
                            if (cnt_q[i] == ONE) st_d[i] = IDLE;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q   <= '0;
            primed_q <= 1'b0;
            ovr_q    <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= IDLE;
                cnt_q[i] <= '0;
            end
        end else begin
            prev_q <= sig;
            if (prime_ok) primed_q <= 1'b1;
            ovr_q <= ovr_d;
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign data_out[g] = (st_q[g] == ACTIVE);
    end

    assign busy    = data_out;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_multi_one_shot.sv
// Directed bench for multi_one_shot: several parameterizations share one stimulus bus.
module tb_multi_one_shot;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] en;
    logic [3:0] data_in;
    logic       clr_overrun;

    logic [3:0] d_out, d_busy, d_ovr;
    logic [3:0] b_out, b_busy, b_ovr;
    logic [3:0] f_out, f_busy, f_ovr;
    logic [3:0] p5_out, p5_busy, p5_ovr;
    logic [3:0] rt_out, rt_busy, rt_ovr;
    logic [3:0] p10_out, p10_busy, p10_ovr;

    int passed = 0;
    int total  = 0;

    always #10 clk = ~clk;

    multi_one_shot u_def (
        .clk(clk), .reset(reset), .en(en), .data_in(data_in),
        .clr_overrun(clr_overrun),
        .data_out(d_out), .busy(d_busy), .overrun(d_ovr)
    );

    multi_one_shot #(.EDGE_MODE(2)) u_both (
        .clk(clk), .reset(reset), .en(en), .data_in(data_in),
        .clr_overrun(clr_overrun),
        .data_out(b_out), .busy(b_busy), .overrun(b_ovr)
    );

    multi_one_shot #(.EDGE_MODE(1)) u_fall (
        .clk(clk), .reset(reset), .en(en), .data_in(data_in),
        .clr_overrun(clr_overrun),
        .data_out(f_out), .busy(f_busy), .overrun(f_ovr)
    );

    multi_one_shot #(.PULSE_W(5)) u_p5 (
        .clk(clk), .reset(reset), .en(en), .data_in(data_in),
        .clr_overrun(clr_overrun),
        .data_out(p5_out), .busy(p5_busy), .overrun(p5_ovr)
    );

    multi_one_shot #(.PULSE_W(5), .RETRIGGER(1)) u_rt (
        .clk(clk), .reset(reset), .en(en), .data_in(data_in),
        .clr_overrun(clr_overrun),
        .data_out(rt_out), .busy(rt_busy), .overrun(rt_ovr)
    );

    multi_one_shot #(.PULSE_W(10)) u_p10 (
        .clk(clk), .reset(reset), .en(en), .data_in(data_in),
        .clr_overrun(clr_overrun),
        .data_out(p10_out), .busy(p10_busy), .overrun(p10_ovr)
    );

    typedef struct {
        logic [3:0] din;
        logic [3:0] en;
        logic       clr;
        logic [3:0] def;
        logic [3:0] both;
        logic [3:0] both_ovr;
        logic [3:0] fall;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] all_outs();
        return {d_out, d_busy, d_ovr, b_out, b_busy, b_ovr,
                f_out, f_busy, f_ovr, p5_out, p5_busy, p5_ovr,
                rt_out, rt_busy, rt_ovr, p10_out, p10_busy, p10_ovr};
    endfunction

    // Async assert, one clock in reset, release just after an edge.
    task automatic do_reset(input logic [3:0] din_v);
        data_in     = din_v;
        en          = 4'b1111;
        clr_overrun = 1'b0;
        reset       = 1'b0;
        #1;
        chk("reset_async", all_outs(), 72'h0);
        step();
        reset = 1'b1;
    endtask

    initial begin
        int n5;
        int nrt;
        int n10;

        reset       = 1'b0;
        data_in     = 4'b0000;
        en          = 4'b1111;
        clr_overrun = 1'b0;

        //         din      en       clr   def      both     b_ovr    fall
        tbl[0]  = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b1111, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tbl[2]  = '{4'b0001, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
        tbl[4]  = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[5]  = '{4'b1111, 4'b1111, 1'b0, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
        tbl[6]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b1111, 4'b0000, 4'b1111};
        tbl[8]  = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[9]  = '{4'b0001, 4'b1111, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        tbl[10] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
        tbl[11] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        tbl[12] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[13] = '{4'b1000, 4'b0111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[14] = '{4'b1000, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        tbl[15] = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b1000, 4'b0000, 4'b1000};

        repeat (4) @(posedge clk);
        #1;
        chk("reset_state", all_outs(), 72'h0);
        #29;
        reset = 1'b1;

        foreach (tbl[i]) begin
            data_in     = tbl[i].din;
            en          = tbl[i].en;
            clr_overrun = tbl[i].clr;
            step();
            chk($sformatf("r%0d_def_out", i), 72'(d_out), 72'(tbl[i].def));
            chk($sformatf("r%0d_def_busy", i), 72'(d_busy), 72'(tbl[i].def));
            chk($sformatf("r%0d_def_ovr", i), 72'(d_ovr), 72'h0);
            chk($sformatf("r%0d_both_out", i), 72'(b_out), 72'(tbl[i].both));
            chk($sformatf("r%0d_both_ovr", i), 72'(b_ovr), 72'(tbl[i].both_ovr));
            chk($sformatf("r%0d_fall_out", i), 72'(f_out), 72'(tbl[i].fall));
        end
        clr_overrun = 1'b0;
        en          = 4'b1111;

        // Inputs high through reset release never fire.
        do_reset(4'b1111);
        for (int s = 0; s < 3; s++) begin
            step();
            chk($sformatf("hi_release_%0d", s), 72'({d_out, b_out, p5_out}), 72'h0);
        end

        // Plain vs retrigger: rise, fall, low, rise 3 cycles into pulse.
        do_reset(4'b0000);
        step();
        data_in = 4'b0010;
        step();
        chk("p5_latency", 72'(p5_out), 72'(4'b0010));
        chk("rt_latency", 72'(rt_out), 72'(4'b0010));
        n5  = 1;
        nrt = 1;
        for (int s = 1; s < 12; s++) begin
            data_in = (s == 1 || s == 2) ? 4'b0000 : 4'b0010;
            step();
            n5  += int'(p5_out[1]);
            nrt += int'(rt_out[1]);
        end
        chk("p5_width", 72'(n5), 72'd5);
        chk("rt_width", 72'(nrt), 72'd8);
        chk("p5_ovr_set", 72'(p5_ovr), 72'(4'b0010));
        chk("rt_ovr_set", 72'(rt_ovr), 72'(4'b0010));
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("p5_ovr_clr", 72'(p5_ovr), 72'h0);
        chk("rt_ovr_clr", 72'(rt_ovr), 72'h0);

        // New overrun in the same cycle as clear keeps the flag.
        data_in = 4'b0000;
        step();
        data_in = 4'b0010;
        step();
        chk("p5_refire", 72'(p5_out), 72'(4'b0010));
        data_in = 4'b0000;
        step();
        data_in     = 4'b0010;
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("ovr_beats_clr", 72'(p5_ovr), 72'(4'b0010));

        // Reset asserted in the middle of a 10-cycle pulse.
        do_reset(4'b0000);
        step();
        data_in = 4'b0001;
        step();
        chk("p10_start", 72'(p10_out), 72'(4'b0001));
        data_in = 4'b0000;
        step();
        data_in = 4'b0001;
        step();
        chk("p10_mid", 72'({p10_out, p10_ovr}), 72'(8'h11));
        step();
        #5;
        reset = 1'b0;
        #1;
        chk("p10_async_rst", 72'({p10_out, p10_busy, p10_ovr}), 72'h0);
        step();
        reset = 1'b1;
        n10 = 0;
        for (int s = 0; s < 12; s++) begin
            step();
            n10 += int'(p10_out[0]) + int'(p10_ovr[0]);
        end
        chk("p10_no_refire", 72'(n10), 72'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
